// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 field bundles into instruction words and streams them out
// at sequential byte addresses. Optional immediate range checking: `IMM_RANGE_CHECK_EN.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  type_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        done,
  output logic        err_invalid,
  output logic        err_range
);

  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  localparam logic [8:0] SEL_R     = 9'h001;
  localparam logic [8:0] SEL_LW    = 9'h002;
  localparam logic [8:0] SEL_ADDI  = 9'h004;
  localparam logic [8:0] SEL_JALR  = 9'h008;
  localparam logic [8:0] SEL_S     = 9'h010;
  localparam logic [8:0] SEL_SB    = 9'h020;
  localparam logic [8:0] SEL_AUIPC = 9'h040;
  localparam logic [8:0] SEL_LUI   = 9'h080;
  localparam logic [8:0] SEL_UJ    = 9'h100;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_LW    = 7'h03;
  localparam logic [6:0] OP_ADDI  = 7'h13;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_SB    = 7'h63;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_UJ    = 7'h6F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic [31:0]       instr_q;
  logic [31:0]       addr_q;
  logic [CNT_W-1:0]  count_q;
  logic              done_q;
  logic              err_invalid_q;

  logic [31:0]       instr_d;
  logic              sel_valid;
  logic              last;
  logic              accept;
  logic              load;
  logic              out_hs;

  // A bundle is only encodable when exactly one format bit is set.
  assign sel_valid = (type_sel != 9'h000) && ((type_sel & (type_sel - 9'h001)) == 9'h000);
  assign last      = (count_q == CNT_W'(MAX_WORDS - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready && !last;
      default: in_ready = 1'b0;
    endcase
    if (rst) begin
      in_ready = 1'b0;
    end
  end

  assign accept = in_valid && in_ready;
  assign load   = accept && sel_valid;
  assign out_hs = out_valid_q && out_ready;

  always_comb begin
    instr_d = 32'h0000_0000;
    case (type_sel)
      SEL_R:     instr_d = {funct7, rs2, rs1, funct3, rd, OP_R};
      SEL_LW:    instr_d = {imm[11:0], rs1, funct3, rd, OP_LW};
      SEL_ADDI:  instr_d = {imm[11:0], rs1, funct3, rd, OP_ADDI};
      SEL_JALR:  instr_d = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      SEL_S:     instr_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
      SEL_SB:    instr_d = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_SB};
      SEL_AUIPC: instr_d = {imm[31:12], rd, OP_AUIPC};
      SEL_LUI:   instr_d = {imm[31:12], rd, OP_LUI};
      SEL_UJ:    instr_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_UJ};
      default:   instr_d = 32'h0000_0000;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic range_bad;
  logic err_range_q;

  // Upper immediate bits must all match the sign bit of the encodable field.
  always_comb begin
    range_bad = 1'b0;
    case (type_sel)
      SEL_LW, SEL_ADDI, SEL_JALR, SEL_S:
        range_bad = !((&imm[31:11]) || !(|imm[31:11]));
      SEL_SB:
        range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      SEL_UJ:
        range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      SEL_AUIPC, SEL_LUI:
        range_bad = |imm[11:0];
      default:
        range_bad = 1'b0;
    endcase
  end

  assign err_range = err_range_q;
`else
  assign err_range = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      instr_q       <= 32'h0000_0000;
      addr_q        <= BASE_ADDR;
      count_q       <= '0;
      done_q        <= 1'b0;
      err_invalid_q <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      err_range_q   <= 1'b0;
`endif
    end else begin
      if (out_hs) begin
        addr_q  <= addr_q + 32'd4;
        count_q <= count_q + 1'b1;
      end

      if (accept && !sel_valid) begin
        err_invalid_q <= 1'b1;
      end

      if (load) begin
        instr_q <= instr_d;
`ifdef IMM_RANGE_CHECK_EN
        if (range_bad) begin
          err_range_q <= 1'b1;
        end
`endif
      end

      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (last) begin
              state_q     <= STOP;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else if (!load) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        STOP: begin
          state_q <= STOP;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = instr_q;
  assign out_addr    = addr_q;
  assign done        = done_q;
  assign err_invalid = err_invalid_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized run scored
// against a queue-based reference model; a second instance covers the word limit and wrap.
module tb_instr_encoder;

  localparam int          MAXW   = 1024;
  localparam logic [31:0] B_BASE = 32'hFFFF_FFF8;

  localparam logic [8:0] S_R     = 9'h001;
  localparam logic [8:0] S_LW    = 9'h002;
  localparam logic [8:0] S_ADDI  = 9'h004;
  localparam logic [8:0] S_JALR  = 9'h008;
  localparam logic [8:0] S_S     = 9'h010;
  localparam logic [8:0] S_SB    = 9'h020;
  localparam logic [8:0] S_AUIPC = 9'h040;
  localparam logic [8:0] S_LUI   = 9'h080;
  localparam logic [8:0] S_UJ    = 9'h100;

`ifdef IMM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [8:0]  type_sel = 9'h000;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;

  logic        in_ready, out_valid, done, err_invalid, err_range;
  logic [31:0] out_instr, out_addr;
  logic        b_in_ready, b_out_valid, b_done, b_err_invalid, b_err_range;
  logic [31:0] b_out_instr, b_out_addr;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .type_sel(type_sel),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .done(done), .err_invalid(err_invalid), .err_range(err_range)
  );

  instr_encoder #(.BASE_ADDR(B_BASE), .MAX_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .type_sel(type_sel),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr), .out_addr(b_out_addr),
    .done(b_done), .err_invalid(b_err_invalid), .err_range(b_err_range)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pending words, words emitted, next address and sticky flags.
  logic [31:0] m_q[$];
  logic [31:0] m_addr;
  logic [31:0] m_last;
  int          m_emit;
  bit          m_stop, m_inv, m_rng;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input logic [8:0] sel, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [31:0] im);
    logic [31:0] regs = (32'(s2) << 20) | (32'(s1) << 15);
    logic [31:0] dst  = 32'(d) << 7;
    logic [31:0] f3s  = 32'(f3) << 12;
    logic [31:0] r    = 32'h0;
    case (sel)
      S_R:     r = (32'(f7) << 25) | regs | f3s | dst | 32'h33;
      S_LW:    r = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | f3s | dst | 32'h03;
      S_ADDI:  r = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | f3s | dst | 32'h13;
      S_JALR:  r = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | dst | 32'h67;
      S_S:     r = (((im >> 5) & 32'h7F) << 25) | regs | f3s | ((im & 32'h1F) << 7) | 32'h23;
      S_SB:    r = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | regs | f3s
                 | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
      S_AUIPC: r = (im & 32'hFFFF_F000) | dst | 32'h17;
      S_LUI:   r = (im & 32'hFFFF_F000) | dst | 32'h37;
      S_UJ:    r = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                 | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | dst | 32'h6F;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic bit ref_range_bad(input logic [8:0] sel, input logic [31:0] im);
    int si = int'(im);
    case (sel)
      S_LW, S_ADDI, S_JALR, S_S: return (si < -2048) || (si > 2047);
      S_SB:                      return (si < -4096) || (si > 4095) || im[0];
      S_UJ:                      return (si < -(1 << 20)) || (si > (1 << 20) - 1) || im[0];
      S_AUIPC, S_LUI:            return (im % 32'd4096) != 32'd0;
      default:                   return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_addr = 32'h0;
    m_last = 32'h0;
    m_emit = 0;
    m_stop = 1'b0;
    m_inv  = 1'b0;
    m_rng  = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven: checks the main DUT, advances the
  // model across the next rising edge, and returns at the following falling edge.
  task automatic tick();
    logic exp_ir;
    bit   hs, acc;
    #1;
    if (rst || m_stop)        exp_ir = 1'b0;
    else if (m_q.size() == 0) exp_ir = 1'b1;
    else                      exp_ir = out_ready && (m_emit != MAXW - 1);
    check("in_ready",    32'(in_ready),    32'(exp_ir));
    check("out_valid",   32'(out_valid),   32'(m_q.size() != 0));
    check("out_instr",   out_instr,        m_last);
    check("out_addr",    out_addr,         m_addr);
    check("done",        32'(done),        32'(m_stop));
    check("err_invalid", 32'(err_invalid), 32'(m_inv));
    check("err_range",   32'(err_range),   32'(m_rng));
    if (rst) begin
      m_reset();
    end else begin
      hs  = (m_q.size() != 0) && out_ready;
      acc = in_valid && exp_ir;
      if (hs) begin
        void'(m_q.pop_front());
        m_emit++;
        m_addr += 32'd4;
        if (m_emit == MAXW) m_stop = 1'b1;
      end
      if (acc) begin
        if ($countones(type_sel) == 1) begin
          m_last = ref_encode(type_sel, rd, rs1, rs2, funct3, funct7, imm);
          m_q.push_back(m_last);
          if (RC && ref_range_bad(type_sel, imm)) m_rng = 1'b1;
        end else begin
          m_inv = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic bundle(input logic [8:0] sel, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im);
    in_valid = 1'b1;
    type_sel = sel;
    rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    tick();
    check("reset_out_instr", out_instr, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    // addi x1, x0, 5
    bundle(S_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    check("addi_instr", out_instr, 32'h0050_0093);
    check("addi_addr",  out_addr,  32'h0);
    in_valid = 1'b0;
    tick();
    check("addi_next_addr", out_addr, 32'h4);

    // lui then add, back-to-back
    bundle(S_LUI, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    tick();
    check("lui_instr", out_instr, 32'h1234_5137);
    bundle(S_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    check("add_instr", out_instr, 32'h0020_81B3);
    check("add_addr",  out_addr,  32'h8);
    check("add_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    // jal x1, 8 held under backpressure
    out_ready = 1'b0;
    bundle(S_UJ, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("uj_hold_instr",    out_instr,         32'h0080_00EF);
      check("uj_hold_in_ready", 32'(in_ready),     32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("uj_single_hs_addr", out_addr, 32'h10);

    // non-one-hot select is dropped without disturbing the stream
    bundle(9'h003, 5'd7, 5'd7, 5'd7, 3'd7, 7'd7, 32'd7);
    tick();
    check("inv_flag",  32'(err_invalid), 32'd1);
    check("inv_valid", 32'(out_valid),   32'd0);
    check("inv_addr",  out_addr,         32'h10);
    bundle(S_ADDI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    tick();
    check("after_inv_addr",  out_addr,  32'h10);
    check("after_inv_instr", out_instr, 32'hFFF0_0293);
    // handshake coinciding with an invalid accept
    bundle(9'h000, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd1);
    tick();
    check("hs_inv_valid", 32'(out_valid), 32'd0);
    check("hs_inv_instr", out_instr,      32'hFFF0_0293);

    // out-of-range addi immediate still emits the truncated word
    bundle(S_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    tick();
    check("range_instr", out_instr,       32'h8000_0093);
    check("range_flag",  32'(err_range),  32'(RC));
    in_valid = 1'b0;
    tick();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 8) type_sel = 9'(32'd1 << $urandom_range(0, 8));
      else                          type_sel = 9'($urandom);
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1:       imm = $urandom & 32'hFFFF_F000;
        2:       imm = 32'($urandom_range(0, 4095)) << 1;
        default: imm = $urandom;
      endcase
      tick();
    end

    // word limit and address wrap on the MAX_WORDS=2 instance
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    bundle(S_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    check("max_w0_valid", 32'(b_out_valid), 32'd1);
    check("max_w0_addr",  b_out_addr,       B_BASE);
    bundle(S_ADDI, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    tick();
    check("max_w1_addr",     b_out_addr,      B_BASE + 32'd4);
    check("max_w1_instr",    b_out_instr,     32'h0020_0113);
    check("max_last_ready",  32'(b_in_ready), 32'd0);
    bundle(S_ADDI, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    check("max_done",      32'(b_done),      32'd1);
    check("max_stop_valid", 32'(b_out_valid), 32'd0);
    check("max_stop_ready", 32'(b_in_ready),  32'd0);
    check("max_wrap_addr", b_out_addr,       32'h0);
    tick();
    check("max_done_sticky", 32'(b_done),     32'd1);
    check("max_still_ready", 32'(b_in_ready), 32'd0);

    // reset while a word is held
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    bundle(S_LUI, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
    tick();
    check("rst_hold_valid", 32'(b_out_valid), 32'd1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    check("rst_drop_valid", 32'(b_out_valid), 32'd0);
    check("rst_drop_addr",  b_out_addr,       B_BASE);
    check("rst_drop_instr", b_out_instr,      32'h0);
    check("rst_in_ready",   32'(b_in_ready),  32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
